// File: rtl/thumb_shift_issue_pkg.sv
// Shared types and encodings for the Thumb-1 shift/move issue stage.
// Holds the FSM states, shifter stype codes and the opcode fields of the accepted forms.
package thumb_shift_issue_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ISSUE  = 2'd2,
        WB     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FORM_IMM  = 2'd0,
        FORM_REG  = 2'd1,
        FORM_MOVI = 2'd2,
        FORM_NONE = 2'd3
    } form_t;

    localparam logic [1:0] STYPE_LSL = 2'b00;
    localparam logic [1:0] STYPE_LSR = 2'b01;
    localparam logic [1:0] STYPE_ASR = 2'b10;

    // instr[15:11]
    localparam logic [4:0] OP5_LSL_IMM  = 5'b00000;
    localparam logic [4:0] OP5_LSR_IMM  = 5'b00001;
    localparam logic [4:0] OP5_ASR_IMM  = 5'b00010;
    localparam logic [4:0] OP5_MOVS_IMM = 5'b00100;

    // instr[15:6]
    localparam logic [9:0] OP10_LSL_REG = 10'b0100000010;
    localparam logic [9:0] OP10_LSR_REG = 10'b0100000011;
    localparam logic [9:0] OP10_ASR_REG = 10'b0100000100;

    // Right shifts encode a 32-bit shift as imm5 = 0; LSL #0 is a plain move.
    function automatic logic [7:0] imm_shift_amount(input logic [1:0] stype,
                                                    input logic [4:0] imm5);
        if ((stype != STYPE_LSL) && (imm5 == 5'd0)) begin
            return 8'd32;
        end
        return {3'b000, imm5};
    endfunction

endpackage

// File: rtl/thumb_shift_opdec.sv
// Combinational decoder for the Thumb-1 shift and MOVS-immediate forms.
// Produces register addresses, shift type, destination and immediate operand.
module thumb_shift_opdec
    import thumb_shift_issue_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic        o_legal,
    output form_t       o_form,
    output logic [1:0]  o_stype,
    output logic [2:0]  o_rd,
    output logic [2:0]  o_rm_addr,
    output logic [2:0]  o_rs_addr,
    output logic [7:0]  o_imm
);

    logic [4:0] w_op5;
    logic [9:0] w_op10;

    assign w_op5  = i_instr[15:11];
    assign w_op10 = i_instr[15:6];

    always_comb begin
        o_legal   = 1'b0;
        o_form    = FORM_NONE;
        o_stype   = STYPE_LSL;
        o_rd      = i_instr[2:0];
        o_rm_addr = i_instr[5:3];
        o_rs_addr = i_instr[5:3];
        o_imm     = 8'd0;
        case (w_op5)
            OP5_LSL_IMM: begin
                o_legal = 1'b1;
                o_form  = FORM_IMM;
                o_stype = STYPE_LSL;
                o_imm   = imm_shift_amount(STYPE_LSL, i_instr[10:6]);
            end
            OP5_LSR_IMM: begin
                o_legal = 1'b1;
                o_form  = FORM_IMM;
                o_stype = STYPE_LSR;
                o_imm   = imm_shift_amount(STYPE_LSR, i_instr[10:6]);
            end
            OP5_ASR_IMM: begin
                o_legal = 1'b1;
                o_form  = FORM_IMM;
                o_stype = STYPE_ASR;
                o_imm   = imm_shift_amount(STYPE_ASR, i_instr[10:6]);
            end
            OP5_MOVS_IMM: begin
                o_legal = 1'b1;
                o_form  = FORM_MOVI;
                o_rd    = i_instr[10:8];
                o_imm   = i_instr[7:0];
            end
            default: begin
                // Register forms: Rdn is both the shifted value and the destination.
                if ((w_op10 == OP10_LSL_REG) || (w_op10 == OP10_LSR_REG) ||
                    (w_op10 == OP10_ASR_REG)) begin
                    o_legal   = 1'b1;
                    o_form    = FORM_REG;
                    o_rm_addr = i_instr[2:0];
                    o_rs_addr = i_instr[5:3];
                    if (w_op10 == OP10_LSR_REG) begin
                        o_stype = STYPE_LSR;
                    end else if (w_op10 == OP10_ASR_REG) begin
                        o_stype = STYPE_ASR;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/thumb_shift_issue.sv
// Serialised issue stage: accepts one Thumb-1 shift/move, reads operands, drives the
// shifter bus, writes the result back and latches the APSR flags.
module thumb_shift_issue
    import thumb_shift_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  rf_addr_m,
    input  logic [31:0] rf_data_m,
    output logic [2:0]  rf_addr_s,
    input  logic [31:0] rf_data_s,
    output logic        sh_en,
    output logic        sh_S,
    output logic [31:0] sh_Rm,
    output logic [7:0]  sh_operand2,
    output logic [1:0]  sh_stype,
    input  logic [31:0] sh_Rd,
    input  logic        sh_carry,
    input  logic        sh_zero,
    input  logic        sh_neg,
    output logic        apsr_c,
    output logic        apsr_z,
    output logic        apsr_n,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    output logic [1:0]  o_dbg_state
);

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both 1; instr_ready is high only in IDLE and never depends on instr_valid.

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_instr;
    logic        r_S;
    logic [31:0] r_Rm;
    logic [7:0]  r_operand2;
    logic [1:0]  r_stype;
    logic [2:0]  r_rd;
    logic        r_apsr_c;
    logic        r_apsr_z;
    logic        r_apsr_n;

    logic        w_legal;
    form_t       w_form;
    logic [1:0]  w_stype;
    logic [2:0]  w_rd;
    logic [2:0]  w_rm_addr;
    logic [2:0]  w_rs_addr;
    logic [7:0]  w_imm;
    logic [31:0] w_rm_val;
    logic [7:0]  w_op2_val;
    logic        w_unused_rs_hi;

    thumb_shift_opdec u_opdec (
        .i_instr   (r_instr),
        .o_legal   (w_legal),
        .o_form    (w_form),
        .o_stype   (w_stype),
        .o_rd      (w_rd),
        .o_rm_addr (w_rm_addr),
        .o_rs_addr (w_rs_addr),
        .o_imm     (w_imm)
    );

    assign rf_addr_m = w_rm_addr;
    assign rf_addr_s = w_rs_addr;
    // Only the low byte of a shift register is a shift amount.
    assign w_unused_rs_hi = ^rf_data_s[31:8];

    always_comb begin
        w_rm_val  = rf_data_m;
        w_op2_val = 8'd0;
        case (w_form)
            FORM_IMM:  w_op2_val = w_imm;
            FORM_REG:  w_op2_val = rf_data_s[7:0];
            FORM_MOVI: w_rm_val  = {24'd0, w_imm};
            default:   w_op2_val = 8'd0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        instr_ready  = 1'b0;
        sh_en        = 1'b0;
        wb_en        = 1'b0;
        illegal      = 1'b0;
        case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                illegal      = ~w_legal;
                w_next_state = w_legal ? ISSUE : IDLE;
            end
            ISSUE: begin
                sh_en        = 1'b1;
                w_next_state = WB;
            end
            WB: begin
                wb_en        = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_instr <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && instr_valid) begin
                r_instr <= instr;
            end
        end
    end

    // Shifter bus registers stay put after WB until the next legal decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_S        <= 1'b0;
            r_Rm       <= 32'd0;
            r_operand2 <= 8'd0;
            r_stype    <= STYPE_LSL;
            r_rd       <= 3'd0;
            r_apsr_c   <= 1'b0;
            r_apsr_z   <= 1'b0;
            r_apsr_n   <= 1'b0;
        end else begin
            if ((r_state == DECODE) && w_legal) begin
                r_S        <= 1'b1;
                r_Rm       <= w_rm_val;
                r_operand2 <= w_op2_val;
                r_stype    <= w_stype;
                r_rd       <= w_rd;
            end
            if (r_state == WB) begin
                r_apsr_c <= sh_carry;
                r_apsr_z <= sh_zero;
                r_apsr_n <= sh_neg;
            end
        end
    end

    assign sh_S        = r_S;
    assign sh_Rm       = r_Rm;
    assign sh_operand2 = r_operand2;
    assign sh_stype    = r_stype;
    assign apsr_c      = r_apsr_c;
    assign apsr_z      = r_apsr_z;
    assign apsr_n      = r_apsr_n;
    assign wb_addr     = wb_en ? r_rd : 3'd0;
    assign wb_data     = wb_en ? sh_Rd : 32'd0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_thumb_shift_issue.sv
// Bench for thumb_shift_issue: random and directed instructions, a reference decoder,
// an expected-transaction queue and a monitor that checks every shifter/writeback pulse.
module tb_thumb_shift_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  rf_addr_m;
    logic [31:0] rf_data_m;
    logic [2:0]  rf_addr_s;
    logic [31:0] rf_data_s;
    logic        sh_en;
    logic        sh_S;
    logic [31:0] sh_Rm;
    logic [7:0]  sh_operand2;
    logic [1:0]  sh_stype;
    logic [31:0] sh_Rd;
    logic        sh_carry;
    logic        sh_zero;
    logic        sh_neg;
    logic        apsr_c;
    logic        apsr_z;
    logic        apsr_n;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic [1:0]  o_dbg_state;

    typedef struct packed {
        logic        ill;
        logic [1:0]  stype;
        logic [31:0] rm;
        logic [7:0]  op2;
        logic [2:0]  rd;
        logic [31:0] res;
        logic [2:0]  flags;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rf[8];
    logic [2:0]  model_apsr;
    bit          mon_on;
    int          checks;
    int          errors;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    thumb_shift_issue dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_addr_m   (rf_addr_m),
        .rf_data_m   (rf_data_m),
        .rf_addr_s   (rf_addr_s),
        .rf_data_s   (rf_data_s),
        .sh_en       (sh_en),
        .sh_S        (sh_S),
        .sh_Rm       (sh_Rm),
        .sh_operand2 (sh_operand2),
        .sh_stype    (sh_stype),
        .sh_Rd       (sh_Rd),
        .sh_carry    (sh_carry),
        .sh_zero     (sh_zero),
        .sh_neg      (sh_neg),
        .apsr_c      (apsr_c),
        .apsr_z      (apsr_z),
        .apsr_n      (apsr_n),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .o_dbg_state (o_dbg_state)
    );

    assign rf_data_m = rf[rf_addr_m];
    assign rf_data_s = rf[rf_addr_s];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural meaning of each accepted encoding, from the instruction fields.
    function automatic exp_t ref_model(input logic [15:0] ins);
        exp_t       e;
        logic [4:0] top;
        logic [4:0] amt;
        logic [2:0] kind;
        e    = '0;
        top  = ins[15:11];
        amt  = ins[10:6];
        kind = ins[8:6] - 3'd2;
        if (top <= 5'd2) begin
            e.stype = top[1:0];
            e.rm    = rf[ins[5:3]];
            e.rd    = ins[2:0];
            e.op2   = (top != 5'd0 && amt == 5'd0) ? 8'd32 : {3'b000, amt};
        end else if (ins[15:9] == 7'b0100000 && ins[8:6] >= 3'd2 && ins[8:6] <= 3'd4) begin
            e.stype = kind[1:0];
            e.rm    = rf[ins[2:0]];
            e.op2   = rf[ins[5:3]][7:0];
            e.rd    = ins[2:0];
        end else if (top == 5'b00100) begin
            e.rm    = {24'd0, ins[7:0]};
            e.op2   = 8'd0;
            e.stype = 2'b00;
            e.rd    = ins[10:8];
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge where instr_ready is back.
    task automatic issue(input logic [15:0] ins);
        exp_t e;
        int   n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", {31'd0, instr_ready}, 32'd1);
        sh_Rd = $urandom;
        {sh_carry, sh_zero, sh_neg} = 3'($urandom_range(0, 7));
        e       = ref_model(ins);
        e.res   = sh_Rd;
        e.flags = {sh_carry, sh_zero, sh_neg};
        exp_q.push_back(e);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 20);
        check("ready_latency", n, e.ill ? 32'd2 : 32'd4);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
        check({tag, "_sh_en"}, {31'd0, sh_en}, 32'd0);
        check({tag, "_wb_en"}, {31'd0, wb_en}, 32'd0);
        check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
        check({tag, "_sh_S"}, {31'd0, sh_S}, 32'd0);
        check({tag, "_sh_Rm"}, sh_Rm, 32'd0);
        check({tag, "_sh_op2"}, {24'd0, sh_operand2}, 32'd0);
        check({tag, "_sh_stype"}, {30'd0, sh_stype}, 32'd0);
        check({tag, "_wb_addr"}, {29'd0, wb_addr}, 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_apsr"}, {29'd0, apsr_c, apsr_z, apsr_n}, 32'd0);
        check({tag, "_state"}, {30'd0, o_dbg_state}, 32'd0);
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < 8; i++) begin
            rf[i] = $urandom;
        end
    endtask

    function automatic logic [15:0] random_instr();
        logic [15:0] ins;
        case ($urandom_range(0, 5))
            0: ins = {3'b000, 2'($urandom_range(0, 2)), 11'($urandom)};
            1: ins = {7'b0100000, 3'($urandom_range(2, 4)), 6'($urandom)};
            2: ins = {5'b00100, 11'($urandom)};
            3: ins = {3'b000, 2'($urandom_range(0, 2)), 5'd0, 6'($urandom)};
            4: ins = {7'b0100000, 3'($urandom), 6'($urandom)};
            default: ins = 16'($urandom);
        endcase
        return ins;
    endfunction

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on && rst) begin
                check("apsr", {29'd0, apsr_c, apsr_z, apsr_n}, {29'd0, model_apsr});
                if (illegal || sh_en || wb_en) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_output", {29'd0, illegal, sh_en, wb_en}, 32'd0);
                    end else begin
                        e = exp_q[0];
                        if (illegal) begin
                            check("illegal_expected", 32'd1, {31'd0, e.ill});
                            void'(exp_q.pop_front());
                        end
                        if (sh_en) begin
                            check("issue_legal", {31'd0, e.ill}, 32'd0);
                            check("issue_S", {31'd0, sh_S}, 32'd1);
                            check("issue_Rm", sh_Rm, e.rm);
                            check("issue_op2", {24'd0, sh_operand2}, {24'd0, e.op2});
                            check("issue_stype", {30'd0, sh_stype}, {30'd0, e.stype});
                        end
                        if (wb_en) begin
                            check("wb_legal", {31'd0, e.ill}, 32'd0);
                            check("wb_hold_Rm", sh_Rm, e.rm);
                            check("wb_hold_op2", {24'd0, sh_operand2}, {24'd0, e.op2});
                            check("wb_hold_stype", {30'd0, sh_stype}, {30'd0, e.stype});
                            check("wb_hold_S", {31'd0, sh_S}, 32'd1);
                            check("wb_addr", {29'd0, wb_addr}, {29'd0, e.rd});
                            check("wb_data", wb_data, e.res);
                            model_apsr = e.flags;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        checks      = 0;
        errors      = 0;
        mon_on      = 1'b0;
        model_apsr  = 3'b000;
        rst         = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'd0;
        sh_Rd       = 32'd0;
        sh_carry    = 1'b0;
        sh_zero     = 1'b0;
        sh_neg      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rf[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_idle("reset");
        mon_on = 1'b1;

        // Directed encodings
        randomize_rf();
        rf[2] = 32'h8000_0001;
        issue(16'h0111);
        issue(16'h0818);
        rf[6] = 32'h0000_0120;
        rf[5] = 32'hF000_0000;
        issue(16'h4135);
        issue(16'h27A5);
        issue(16'hB000);
        issue(16'h0000);
        issue(16'h1000);

        // Abort during ISSUE
        randomize_rf();
        sh_Rd = $urandom;
        {sh_carry, sh_zero, sh_neg} = 3'b111;
        e       = ref_model(16'h0123);
        e.res   = sh_Rd;
        e.flags = 3'b111;
        exp_q.push_back(e);
        instr       = 16'h0123;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_apsr = 3'b000;
        @(negedge clk);
        check_idle("abort");
        issue(16'h27A5);

        // Random traffic with idle gaps
        for (int k = 0; k < 80; k++) begin
            randomize_rf();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(random_instr());
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thumb_shift_issue.md
THUMB_SHIFT_ISSUE -- requirements
Module: thumb_shift_issue

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge; the shifter stage samples on the falling edge.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 instr_valid in 1 / instr in 16 / instr_ready out 1  Thumb-1 instruction input handshake.
REQ-004 rf_addr_m out 3, rf_data_m in 32; rf_addr_s out 3, rf_data_s in 32  asynchronous register-file read ports.
REQ-005 sh_en out 1, sh_S out 1, sh_Rm out 32, sh_operand2 out 8, sh_stype out 2  issue bus to the shifter stage (en_inst, S, Rm, operand2, stype).
REQ-006 sh_Rd in 32, sh_carry in 1, sh_zero in 1, sh_neg in 1  result and flags from the shifter stage.
REQ-007 apsr_c, apsr_z, apsr_n  out 1 each  held flag registers, wired to the shifter's carry_in/zero_in/neg_in.
REQ-008 wb_en out 1, wb_addr out 3, wb_data out 32  register-file write port; illegal out 1  undecodable-instruction pulse.

Function
REQ-009 FSM states IDLE, DECODE, ISSUE, WB; instr_ready SHALL be 1 only in IDLE.
REQ-010 Accept on rising edge with instr_valid&instr_ready (cycle N): instr captured, IDLE->DECODE; without valid, FSM stays IDLE.
REQ-011 DECODE (N+1): rf_addr_m/rf_addr_s driven from the captured instr; operands and decode results registered at the end of the cycle; legal -> ISSUE, illegal -> IDLE.
REQ-012 ISSUE (N+2): sh_en=1 for exactly this cycle; sh_S, sh_Rm, sh_operand2, sh_stype held stable from the start of ISSUE through the end of WB.
REQ-013 WB (N+3): wb_en=1 for one cycle; wb_data=sh_Rd, wb_addr=Rd; apsr_c/z/n<=sh_carry/sh_zero/sh_neg at the end of WB; WB->IDLE; instr_ready=1 in N+4.
REQ-014 LSL imm (instr[15:11]=00000): stype 00, Rm=R[instr[5:3]], operand2=imm5 (imm5=0 is MOVS Rd,Rm, operand2=0), Rd=instr[2:0].
REQ-015 LSR imm (00001) and ASR imm (00010): stype 01 and 10 respectively; operand2=imm5, except imm5=0 -> operand2=32.
REQ-016 Register forms (instr[15:6]=0100000010/0011/0100 = LSL/LSR/ASR): Rm=R[instr[2:0]], operand2=R[instr[5:3]][7:0] unmodified (values >=32 included), Rd=instr[2:0].
REQ-017 MOVS imm (instr[15:11]=00100): Rm=zero-extended imm8, operand2=0, stype 00, Rd=instr[10:8].
REQ-018 All legal forms SHALL drive sh_S=1.
REQ-019 Any other encoding: illegal=1 during DECODE only; no sh_en, no wb_en, flags unchanged; the instruction is consumed.
REQ-020 Inactive outputs: sh_en, wb_en, illegal = 0 outside the states named above.
REQ-021 Fully serialised (one instruction per 4 cycles), so no read-after-write hazard logic.

Reset
REQ-022 rst=0 at a rising edge: FSM->IDLE; all registered outputs, apsr flags and captured instr cleared to 0; instr_ready=1 from the first cycle after release.
REQ-023 Reset during DECODE/ISSUE/WB SHALL abort the instruction: no wb_en, flags not updated.

Structure
REQ-024 The shared package SHALL hold the FSM state enum, the stype encodings (LSL=00, LSR=01, ASR=10) and the opcode-field constants of REQ-014..017.
REQ-025 Decode SHALL be a combinational sub-module thumb_shift_opdec (instr -> legal, stype, Rd, Rm/Rs addresses, imm, form select).

Verification
REQ-026 0x0111 (LSLS r1,r2,#4), r2=0x80000001 -> ISSUE: sh_Rm=0x80000001, sh_operand2=4, sh_stype=00, sh_S=1; WB at N+3: wb_addr=1, wb_data=sh_Rd.
REQ-027 0x0818 (LSRS r0,r3,#0) -> sh_operand2=32, sh_stype=01, wb_addr=0.
REQ-028 0x4135 (ASRS r5,r6), r6=0x00000120, r5=0xF0000000 -> sh_Rm=0xF0000000, sh_operand2=0x20, sh_stype=10, wb_addr=5.
REQ-029 0x27A5 (MOVS r7,#0xA5) -> sh_Rm=0x000000A5, sh_operand2=0, wb_addr=7; apsr updated from the sh flags at the end of WB.
REQ-030 0xB000 -> illegal=1 in N+1, no sh_en/wb_en, instr_ready=1 in N+2, apsr unchanged.
REQ-031 rst=0 during ISSUE -> no wb_en, all outputs 0 the next cycle, and a following instr is accepted normally.
